// File: rtl/ovl_fire_arb_pkg.sv
// rtl/ovl_fire_arb_pkg.sv - shared types and helpers for the fire report arbiter
package ovl_fire_arb_pkg;

    // Legal range of requester counts for the round-robin picker
    localparam int RR_MIN_REQ = 2;
    localparam int RR_MAX_REQ = 32;
    // Widest checker index the picker can return
    localparam int RR_MAX_ID_WIDTH = $clog2(RR_MAX_REQ);

    // Largest value representable by an unsigned counter of width w
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Report record in its default widths, for sinks elsewhere in the codebase
    typedef struct packed {
        logic [RR_MAX_ID_WIDTH-1:0] id;
        logic [7:0]                 count;
        logic                       sat;
    } ovl_fire_rec_t;

    // Simulation-only input integrity errors
    typedef enum logic [1:0] {
        OVL_ERR_NONE = 2'd0,
        OVL_ERR_XZ   = 2'd1
    } ovl_error_t;

endpackage

// File: rtl/ovl_rr_pick.sv
// rtl/ovl_rr_pick.sv - combinational rotate-priority picker over a request vector
module ovl_rr_pick
    import ovl_fire_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                any,
    output logic [ID_WIDTH-1:0] grant_idx
);

    // Scan starting one past the last grant, wrapping; first requester found wins
    always_comb begin
        logic w_found;
        int   w_idx;
        any       = |req;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(last) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                grant_idx = ID_WIDTH'(w_idx);
                w_found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ovl_fire_report_arbiter.sv
// rtl/ovl_fire_report_arbiter.sv - coalesces checker fire pulses into round-robin report records
module ovl_fire_report_arbiter
    import ovl_fire_arb_pkg::*;
#(
    parameter int NUM_CHECKERS = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int ID_WIDTH     = $clog2(NUM_CHECKERS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_CHECKERS-1:0] fire,
    output logic                    rpt_valid,
    input  logic                    rpt_ready,
    output logic [ID_WIDTH-1:0]     rpt_id,
    output logic [CNT_WIDTH-1:0]    rpt_count,
    output logic                    rpt_sat,
    output logic [NUM_CHECKERS-1:0] pending
);

    localparam logic [CNT_WIDTH-1:0] L_CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic [NUM_CHECKERS-1:0] w_pending;
    logic [CNT_WIDTH-1:0]    w_cnt [NUM_CHECKERS];
    logic [NUM_CHECKERS-1:0] w_sat;
    logic                    w_any;
    logic [ID_WIDTH-1:0]     w_grant;
    logic                    w_load;

    logic                    r_valid;
    logic [ID_WIDTH-1:0]     r_id;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    r_sat;
    logic [ID_WIDTH-1:0]     r_last;

    ovl_rr_pick #(
        .NUM_REQ  (NUM_CHECKERS),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req       (w_pending),
        .last      (r_last),
        .any       (w_any),
        .grant_idx (w_grant)
    );

    // A new record may enter the output slot when it is empty or draining this cycle
    assign w_load = enable && w_any && (!r_valid || rpt_ready);

    for (genvar gi = 0; gi < NUM_CHECKERS; gi++) begin : g_chk
        logic                 w_clr;
        logic                 r_pend;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_csat;

        assign w_clr        = w_load && (w_grant == ID_WIDTH'(gi));
        assign w_pending[gi] = r_pend;
        assign w_cnt[gi]     = r_cnt;
        assign w_sat[gi]     = r_csat;

        // Per-checker pending/count/sticky-sat; a fire during its own grant restarts the count at 1
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pend <= 1'b0;
                r_cnt  <= '0;
                r_csat <= 1'b0;
            end else if (enable) begin
                if (w_clr) begin
                    r_pend <= fire[gi];
                    r_cnt  <= fire[gi] ? CNT_WIDTH'(1) : '0;
                    r_csat <= 1'b0;
                end else if (fire[gi]) begin
                    r_pend <= 1'b1;
                    if (r_cnt == L_CNT_MAX) begin
                        r_csat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Output record slot: load the granted checker, or empty the slot after a handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_last  <= ID_WIDTH'(NUM_CHECKERS - 1);
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_id    <= w_grant;
            r_count <= w_cnt[w_grant];
            r_sat   <= w_sat[w_grant];
            r_last  <= w_grant;
        end else if (r_valid && rpt_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rpt_valid = r_valid;
    assign rpt_id    = r_id;
    assign rpt_count = r_count;
    assign rpt_sat   = r_sat;
    assign pending   = w_pending;

`ifndef SYNTHESIS
`ifndef OVL_XCHECK_OFF
    ovl_error_t w_xerr;
    assign w_xerr = (reset_n && $isunknown({fire, enable, rpt_ready})) ? OVL_ERR_XZ : OVL_ERR_NONE;

    // Flag unknown control inputs while out of reset
    always_ff @(posedge clk) begin
        assert (w_xerr == OVL_ERR_NONE)
            else $error("ovl_fire_report_arbiter: %s on fire/enable/rpt_ready", w_xerr.name());
    end
`endif
`endif

endmodule

// File: tb/tb_ovl_fire_report_arbiter.sv
// tb/tb_ovl_fire_report_arbiter.sv - directed self-checking bench for the fire report arbiter
module tb_ovl_fire_report_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       enable = 1'b0;
    logic [3:0] fire = 4'b0;
    logic       rpt_ready = 1'b1;
    logic       rpt_valid;
    logic [1:0] rpt_id;
    logic [7:0] rpt_count;
    logic       rpt_sat;
    logic [3:0] pending;

    logic       en_s = 1'b0;
    logic [3:0] fire_s = 4'b0;
    logic       rdy_s = 1'b1;
    logic       valid_s;
    logic [1:0] id_s;
    logic [1:0] cnt_s;
    logic       sat_s;
    logic [3:0] pend_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ovl_fire_report_arbiter #(.NUM_CHECKERS(4), .CNT_WIDTH(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .fire      (fire),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_id    (rpt_id),
        .rpt_count (rpt_count),
        .rpt_sat   (rpt_sat),
        .pending   (pending)
    );

    ovl_fire_report_arbiter #(.NUM_CHECKERS(4), .CNT_WIDTH(2)) u_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (en_s),
        .fire      (fire_s),
        .rpt_valid (valid_s),
        .rpt_ready (rdy_s),
        .rpt_id    (id_s),
        .rpt_count (cnt_s),
        .rpt_sat   (sat_s),
        .pending   (pend_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic rec(input string tag, input logic v, input logic [1:0] id,
                       input logic [7:0] cnt, input logic sat);
        check({tag, ".valid"}, rpt_valid, v);
        if (v) begin
            check({tag, ".id"}, rpt_id, id);
            check({tag, ".count"}, rpt_count, cnt);
            check({tag, ".sat"}, rpt_sat, sat);
        end
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        #12;
        check("rst.valid", rpt_valid, 1'b0);
        check("rst.id", rpt_id, 2'd0);
        check("rst.count", rpt_count, 8'd0);
        check("rst.sat", rpt_sat, 1'b0);
        check("rst.pending", pending, 4'b0);
        check("rst.valid_s", valid_s, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: single fire on checker 2
        enable = 1'b1; rpt_ready = 1'b1; fire = 4'b0100;
        tick();
        fire = 4'b0;
        check("t1.pending", pending, 4'b0100);
        check("t1.early", rpt_valid, 1'b0);
        tick();
        rec("t1.rec", 1'b1, 2'd2, 8'd1, 1'b0);
        check("t1.pend_clr", pending, 4'b0);
        tick();
        check("t1.drop", rpt_valid, 1'b0);

        // 2: round robin from reset pointer
        do_reset();
        fire = 4'b1111;
        tick();
        fire = 4'b0;
        check("t2.pending", pending, 4'b1111);
        tick(); rec("t2.r0", 1'b1, 2'd0, 8'd1, 1'b0);
        tick(); rec("t2.r1", 1'b1, 2'd1, 8'd1, 1'b0);
        tick(); rec("t2.r2", 1'b1, 2'd2, 8'd1, 1'b0);
        tick(); rec("t2.r3", 1'b1, 2'd3, 8'd1, 1'b0);
        tick(); check("t2.idle", rpt_valid, 1'b0);
        fire = 4'b1001;
        tick();
        fire = 4'b0;
        tick(); rec("t2.r0b", 1'b1, 2'd0, 8'd1, 1'b0);
        tick(); rec("t2.r3b", 1'b1, 2'd3, 8'd1, 1'b0);
        tick(); check("t2.idle2", rpt_valid, 1'b0);

        // 3: backpressure and coalescing on checker 1 behind a held record
        do_reset();
        rpt_ready = 1'b0;
        fire = 4'b0001;
        tick();
        fire = 4'b0;
        tick();
        rec("t3.hold0", 1'b1, 2'd0, 8'd1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            fire = 4'b0010;
            tick();
        end
        fire = 4'b0;
        rec("t3.stable0", 1'b1, 2'd0, 8'd1, 1'b0);
        check("t3.pend1", pending, 4'b0010);
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        rec("t3.rec1", 1'b1, 2'd1, 8'd5, 1'b0);
        check("t3.pend_clr", pending, 4'b0);
        tick();
        rec("t3.stable1", 1'b1, 2'd1, 8'd5, 1'b0);
        rpt_ready = 1'b1;
        tick();
        check("t3.xfer", rpt_valid, 1'b0);
        tick();
        check("t3.once", rpt_valid, 1'b0);
        check("t3.pend_end", pending, 4'b0);

        // 4: saturation with a 2-bit counter
        do_reset();
        enable = 1'b0;
        en_s = 1'b1; rdy_s = 1'b0;
        fire_s = 4'b0010;
        tick();
        fire_s = 4'b0;
        tick();
        check("t4.hold.valid", valid_s, 1'b1);
        check("t4.hold.id", id_s, 2'd1);
        for (int n = 0; n < 6; n++) begin
            fire_s = 4'b0001;
            tick();
        end
        fire_s = 4'b0;
        check("t4.pend", pend_s, 4'b0001);
        rdy_s = 1'b1;
        tick();
        check("t4.sat.valid", valid_s, 1'b1);
        check("t4.sat.id", id_s, 2'd0);
        check("t4.sat.count", cnt_s, 2'd3);
        check("t4.sat.sat", sat_s, 1'b1);
        tick();
        check("t4.drain", valid_s, 1'b0);
        fire_s = 4'b0001;
        tick();
        fire_s = 4'b0;
        tick();
        check("t4.fresh.valid", valid_s, 1'b1);
        check("t4.fresh.id", id_s, 2'd0);
        check("t4.fresh.count", cnt_s, 2'd1);
        check("t4.fresh.sat", sat_s, 1'b0);
        en_s = 1'b0;

        // 5: fire on checker 2 on the edge that loads it
        do_reset();
        enable = 1'b1; rpt_ready = 1'b0;
        fire = 4'b0001;
        tick();
        fire = 4'b0;
        tick();
        for (int n = 0; n < 4; n++) begin
            fire = 4'b0100;
            tick();
        end
        fire = 4'b0100; rpt_ready = 1'b1;
        tick();
        fire = 4'b0;
        rec("t5.old", 1'b1, 2'd2, 8'd4, 1'b0);
        check("t5.pend", pending, 4'b0100);
        tick();
        rec("t5.new", 1'b1, 2'd2, 8'd1, 1'b0);
        check("t5.pend_clr", pending, 4'b0);
        tick();
        check("t5.idle", rpt_valid, 1'b0);

        // 6: enable=0 holds state; reset drops a valid record asynchronously
        do_reset();
        rpt_ready = 1'b0;
        fire = 4'b0001;
        tick();
        fire = 4'b0;
        tick();
        fire = 4'b0100;
        tick();
        check("t6.pend", pending, 4'b0100);
        enable = 1'b0; fire = 4'b1111;
        tick();
        tick();
        check("t6.dis.pend", pending, 4'b0100);
        rec("t6.dis.hold", 1'b1, 2'd0, 8'd1, 1'b0);
        fire = 4'b0; rpt_ready = 1'b1;
        tick();
        check("t6.dis.xfer", rpt_valid, 1'b0);
        tick();
        check("t6.dis.noload", rpt_valid, 1'b0);
        check("t6.dis.pend2", pending, 4'b0100);
        enable = 1'b1; rpt_ready = 1'b0;
        tick();
        rec("t6.en.rec", 1'b1, 2'd2, 8'd1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6.rst.valid", rpt_valid, 1'b0);
        check("t6.rst.pend", pending, 4'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6.post.valid", rpt_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovl_fire_report_arbiter.md
Name: ovl_fire_report_arbiter

Overview:
- Shares one report channel among NUM_CHECKERS window checkers.
- Each checker raises a 1-cycle fire pulse.
- The block records each pulse as a per-checker pending flag with a saturating coalesced count.
- It grants pending checkers in round-robin order and presents one report record at a time on a valid/ready channel to the single message/logging sink.

Parameters:
- NUM_CHECKERS, 4, number of fire inputs (2..32).
- CNT_WIDTH, 8, width of per-checker coalesced fire count.
- ID_WIDTH, $clog2(NUM_CHECKERS), width of checker index. Derived; do not override.

Ports:
- clk  input  1  sampling clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = accept fires and issue grants.
- fire  input  NUM_CHECKERS  per-checker fire pulse; bit i from checker i.
- rpt_valid  output  1  report record valid.
- rpt_ready  input  1  sink accepts record.
- rpt_id  output  ID_WIDTH  index of reported checker.
- rpt_count  output  CNT_WIDTH  fires coalesced for rpt_id since its previous report (1..max).
- rpt_sat  output  1  rpt_count saturated; further fires were dropped.
- pending  output  NUM_CHECKERS  per-checker pending flags (status).

Behaviour:
- Reset (async assert, sync release), all state cleared:
  - rpt_valid=0, rpt_id=0, rpt_count=0, rpt_sat=0, pending=0.
  - Per-checker counts = 0.
  - Round-robin pointer: last-granted = NUM_CHECKERS-1, so checker 0 has first priority.
- Fire capture, on each rising clk edge with enable=1, for each i with fire[i]=1:
  - pending[i] <= 1.
  - cnt[i] <= cnt[i]+1, saturating at 2^CNT_WIDTH-1.
  - An increment attempted at max sets sticky sat[i].
- enable=0:
  - fire ignored.
  - pending, cnt and sat are held.
  - No new record is loaded.
  - A record already valid stays valid until handshake.
- Load condition: load = enable && |pending && (!rpt_valid || rpt_ready).
- Grant selection:
  - Rotate-priority over pending, starting at (last-granted+1) mod NUM_CHECKERS, wrapping.
  - Combinational from registered pending.
- On load, at the rising edge:
  - rpt_valid<=1, rpt_id<=g, rpt_count<=cnt[g], rpt_sat<=sat[g].
  - Clear pending[g], cnt[g], sat[g].
  - last-granted<=g.
- Same-cycle fire on g during its load:
  - The record takes the old count.
  - The new count restarts: pending[g]=1, cnt[g]=1, sat[g]=0.
  - No fire is lost.
- Handshake:
  - Transfer occurs on an edge with rpt_valid&&rpt_ready.
  - If no load occurs at that edge, rpt_valid<=0.
  - Back-to-back records are allowed: one per cycle when ready is held high.
- Stability: while rpt_valid=1 and rpt_ready=0, rpt_id, rpt_count and rpt_sat are held stable.
- Latency: fire sampled at edge k -> pending at k; earliest rpt_valid after edge k+1.
- Fairness: with all checkers continuously pending, each is granted exactly once per NUM_CHECKERS grants.
- Reset mid-transfer: rpt_valid drops immediately; the record is discarded.
- X/Z handling: an X/Z on fire, enable or rpt_ready while reset_n=1 triggers a simulation-only error via ovl_error_t. Guarded by OVL_XCHECK_OFF.

Decomposition:
- Package ovl_fire_arb_pkg holds:
  - rr_pick function signature constants.
  - CNT_MAX localparam helper.
  - A record struct {id, count, sat} for wider-codebase reuse.
- One sub-module: ovl_rr_pick.
  - Purely combinational.
  - Inputs: req[NUM_CHECKERS], last[ID_WIDTH].
  - Outputs: any, grant_idx.
  - Instantiated once.

Test Plan:
1. Reset then single fire[2] at edge k, rpt_ready=1 -> rpt_valid=1 after edge k+1 with id=2, count=1, sat=0; rpt_valid=0 after edge k+2.
2. Round robin: fire=4'b1111 for one cycle, rpt_ready=1 -> ids 0,1,2,3 on four consecutive cycles, each count=1. Then fire=4'b1001 -> ids 0,3.
3. Backpressure/coalescing: rpt_ready=0, fire[1] pulsed 5 times -> one record id=1, count=5 held stable; after ready=1, exactly one transfer and pending[1]=0.
4. Saturation: CNT_WIDTH=2, rpt_ready=0, fire[0] 6 times -> count=3, sat=1; next report after a fresh single fire -> count=1, sat=0.
5. Collision: fire[2] on the same edge that loads id=2 (count=4) -> record count=4; pending[2]=1 with cnt=1; next record id=2 count=1.
6. Control: enable=0 with fire=4'b1111 -> pending unchanged, no new rpt_valid. Assert reset_n=0 while rpt_valid=1 -> rpt_valid=0 before the next clk edge.
